fp_posit_multiplier: RTL and testbench

Bit-serial multiplier for a mixed-precision MAC datapath. It takes an FP16 activation (parallel) and a posit weight (es = 0, 3–5 bits) streamed MSB-first one bit per clock. Once a weight word is complete, it outputs the sign, a 5-bit exponent and an unnormalized 14-bit integer significand product. The normalization/accumulation stage downstream consumes the result.

---
 rtl/fp_posit_multiplier.sv | 110 +++++++++++
 tb/tb_fp_posit_multiplier.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fp_posit_multiplier.sv
// Bit-serial FP16 x posit(es=0, n=3..5) multiplier: collects the weight MSB-first,
// then emits sign, biased exponent and the unnormalized integer significand product.
module fp_posit_multiplier #(
  parameter int ACT_WIDTH = 16,
  parameter int EXP_WIDTH = 5,
  parameter int MAN_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ACT_WIDTH-1:0]   act,
  input  logic                   w,
  input  logic                   valid,
  input  logic                   set,
  input  logic [3:0]             precision,
  output logic                   sign_out,
  output logic [EXP_WIDTH-1:0]   exp_out,
  output logic [MAN_WIDTH+3:0]   mantissa_out,
  output logic                   done
);
  localparam int PW = MAN_WIDTH + 4;

  logic [2:0] prec_reg, cnt_reg;
  logic [3:0] shift_reg;

  logic [4:0] word, aligned, mag;
  logic [3:0] body;
  logic [2:0] m, run, consumed, f, tail, sw, prec_clamped;
  logic       rbit, ps, is_zero, is_nar, complete;
  logic [EXP_WIDTH-1:0] act_exp, k_val, exp_calc;
  logic [MAN_WIDTH:0]   sa;
  logic [PW-1:0]        prod;

  always_comb begin
    word    = {shift_reg, w};
    // Left-align the n-bit word into 5 bits so decoding is independent of n.
    aligned = word << (3'd5 - prec_reg);
    ps      = aligned[4];
    is_zero = (aligned == 5'd0);
    is_nar  = (aligned == 5'b10000);
    mag     = ps ? (5'd0 - aligned) : aligned;
    body    = mag[3:0];
    m       = prec_reg - 3'd1;
    rbit    = body[3];

    run = 3'd1;
    if (body[2] == rbit) begin
      run = 3'd2;
      if (m >= 3'd3 && body[1] == rbit) begin
        run = 3'd3;
        if (m == 3'd4 && body[0] == rbit) run = 3'd4;
      end
    end
    consumed = (run < m) ? run + 3'd1 : run;
    f        = m - consumed;
    // body[3] is always part of the regime, so it never reaches the fraction.
    tail     = body[2:0] >> (3'd4 - m);
    sw       = (3'd1 << f) | (tail & ((3'd1 << f) - 3'd1));

    act_exp  = act[MAN_WIDTH +: EXP_WIDTH];
    k_val    = rbit ? (EXP_WIDTH'(run) - EXP_WIDTH'(1)) : (EXP_WIDTH'(0) - EXP_WIDTH'(run));
    exp_calc = act_exp + k_val - EXP_WIDTH'(f);
    sa       = {|act_exp, act[MAN_WIDTH-1:0]};
    prod     = PW'(sa) * PW'(sw);

    complete = valid && !set && (cnt_reg == m);
    prec_clamped = (precision < 4'd3) ? 3'd3 :
                   (precision > 4'd5) ? 3'd5 : precision[2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prec_reg     <= 3'd4;
      cnt_reg      <= 3'd0;
      shift_reg    <= 4'd0;
      sign_out     <= 1'b0;
      exp_out      <= '0;
      mantissa_out <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (set) begin
        prec_reg  <= prec_clamped;
        cnt_reg   <= 3'd0;
        shift_reg <= 4'd0;
      end else if (valid) begin
        if (complete) begin
          cnt_reg   <= 3'd0;
          shift_reg <= 4'd0;
          done      <= 1'b1;
          if (is_zero) begin
            sign_out     <= 1'b0;
            exp_out      <= '0;
            mantissa_out <= '0;
          end else if (is_nar) begin
            sign_out     <= 1'b0;
            exp_out      <= '1;
            mantissa_out <= '1;
          end else begin
            sign_out     <= act[ACT_WIDTH-1] ^ ps;
            exp_out      <= exp_calc;
            mantissa_out <= prod;
          end
        end else begin
          cnt_reg   <= cnt_reg + 3'd1;
          shift_reg <= {shift_reg[2:0], w};
        end
      end
    end
  end
endmodule

// File: tb/tb_fp_posit_multiplier.sv
// Bench for fp_posit_multiplier: directed cases plus random words checked against
// an integer-arithmetic posit/FP16 reference model.
module tb_fp_posit_multiplier;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] act = 16'd0;
  logic        w = 1'b0, valid = 1'b0, set = 1'b0;
  logic [3:0]  precision = 4'd0;
  logic        sign_out;
  logic [4:0]  exp_out;
  logic [13:0] mantissa_out;
  logic        done;

  int checks = 0, failures = 0;
  int cur_n = 4;
  logic        last_s = 1'b0;
  logic [4:0]  last_e = 5'd0;
  logic [13:0] last_m = 14'd0;

  fp_posit_multiplier dut (
    .clk(clk), .rst(rst), .act(act), .w(w), .valid(valid), .set(set),
    .precision(precision), .sign_out(sign_out), .exp_out(exp_out),
    .mantissa_out(mantissa_out), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Posit value = (-1)^ps * 2^k * (1.F); product exponent accounts for the f fraction bits.
  function automatic void ref_model(input int n, input int word, input logic [15:0] a,
                                    output logic s, output logic [4:0] e, output logic [13:0] mn);
    int mask, v, idx, first, r, f, fr, sw, k, ae, sa, ps;
    mask = (1 << n) - 1;
    word = word & mask;
    if (word == 0) begin
      s = 1'b0; e = 5'd0; mn = 14'd0;
    end else if (word == (1 << (n - 1))) begin
      s = 1'b0; e = 5'h1f; mn = 14'h3fff;
    end else begin
      ps = (word >> (n - 1)) & 1;
      v = ps != 0 ? ((-word) & mask) : word;
      idx = n - 2;
      first = (v >> idx) & 1;
      r = 0;
      while (idx >= 0 && ((v >> idx) & 1) == first) begin
        r++;
        idx--;
      end
      if (idx >= 0) idx--;
      f = idx + 1;
      fr = v & ((1 << f) - 1);
      sw = (1 << f) | fr;
      k = first != 0 ? r - 1 : -r;
      ae = int'(a[14:10]);
      sa = (ae != 0 ? 1024 : 0) + int'(a[9:0]);
      s = a[15] ^ ps[0];
      e = 5'((ae + k - f) & 31);
      mn = 14'(sa * sw);
    end
  endfunction

  task automatic step(input logic v, input logic b, input logic [15:0] a,
                      input logic s_set, input logic [3:0] p);
    @(negedge clk);
    valid = v; w = b; act = a; set = s_set; precision = p;
    @(posedge clk);
    #1;
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_sign"}, 32'(sign_out), 32'(last_s));
    chk({tag, "_exp"},  32'(exp_out),  32'(last_e));
    chk({tag, "_man"},  32'(mantissa_out), 32'(last_m));
  endtask

  task automatic send_word(input int word, input logic [15:0] a, input int gap_pct, input string tag);
    logic es; logic [4:0] ee; logic [13:0] em;
    ref_model(cur_n, word, a, es, ee, em);
    for (int i = cur_n - 1; i >= 0; i--) begin
      for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) begin
        step(1'b0, 1'($urandom), 16'($urandom), 1'b0, 4'($urandom));
        check_held({tag, "_gap"});
      end
      step(1'b1, 1'((word >> i) & 1), (i == 0) ? a : 16'($urandom), 1'b0, 4'($urandom));
      if (i > 0) begin
        chk({tag, "_mid_done"}, 32'(done), 32'd0);
      end else begin
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_sign"}, 32'(sign_out), 32'(es));
        chk({tag, "_exp"},  32'(exp_out),  32'(ee));
        chk({tag, "_man"},  32'(mantissa_out), 32'(em));
        last_s = es; last_e = ee; last_m = em;
      end
    end
    $display("word n=%0d w=%0h act=%04h -> s=%0b e=%0d m=%0d (exp s=%0b e=%0d m=%0d)",
             cur_n, word & ((1 << cur_n) - 1), a, sign_out, exp_out, mantissa_out, es, ee, em);
  endtask

  task automatic do_set(input logic [3:0] p);
    step(1'($urandom), 1'($urandom), 16'($urandom), 1'b1, p);
    cur_n = (p < 3) ? 3 : (p > 5) ? 5 : int'(p);
    check_held("set");
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sign", 32'(sign_out), 32'd0);
    chk("rst_exp",  32'(exp_out), 32'd0);
    chk("rst_man",  32'(mantissa_out), 32'd0);
    @(negedge clk) rst = 1'b0;

    send_word(4'b0011, 16'h1234, 0, "tp_pos");
    chk("tp_pos_lit", 32'(mantissa_out), 32'd4764);
    send_word(4'b0011, 16'hF234, 0, "tp_b2b");
    chk("tp_b2b_lit", 32'(exp_out), 32'h1a);
    send_word(4'b1101, 16'h1234, 0, "tp_neg");
    chk("tp_neg_lit", 32'(sign_out), 32'd1);
    send_word(4'b0000, 16'h5678, 0, "tp_zero");
    chk("tp_zero_lit", 32'(mantissa_out), 32'd0);
    send_word(4'b1000, 16'h5678, 0, "tp_nar");
    chk("tp_nar_lit", 32'(mantissa_out), 32'h3fff);

    do_set(4'd5);
    send_word(5'b01011, 16'h3C00, 0, "tp_p5");
    chk("tp_p5_lit", 32'(mantissa_out), 32'd7168);
    do_set(4'd9);
    send_word(5'b01011, 16'h3C00, 0, "tp_p9");
    chk("tp_p9_lit", 32'(exp_out), 32'd13);

    // Async reset mid-word: outputs clear before any clock edge.
    step(1'b1, 1'b1, 16'h0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 4'd0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_man", 32'(mantissa_out), 32'd0);
    chk("midrst_exp", 32'(exp_out), 32'd0);
    @(negedge clk) rst = 1'b0;
    valid = 1'b0;
    cur_n = 4; last_s = 1'b0; last_e = 5'd0; last_m = 14'd0;
    send_word(4'b0011, 16'h1234, 0, "after_rst");

    // set mid-word drops the partial word.
    step(1'b1, 1'b0, 16'h0, 1'b0, 4'd0);
    step(1'b1, 1'b1, 16'h0, 1'b0, 4'd0);
    chk("partial_done", 32'(done), 32'd0);
    do_set(4'd3);
    send_word(3'b011, 16'h4321, 0, "after_set");

    do_set(4'd4);
    send_word(4'b0011, 16'h1234, 50, "gaps");
    chk("gaps_lit", 32'(mantissa_out), 32'd4764);

    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(9) == 0) do_set(4'($urandom));
      send_word(int'($urandom_range(31)), 16'($urandom), 20, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
